// File: rtl/aes_seq_ctrl_if.sv
// Register-file and AES-core signals seen by the block sequencer.
// master = sequencer side, slave = register file / core side.
interface aes_seq_ctrl_if;
   logic [127:0] reg_conf;
   logic [127:0] key;
   logic [127:0] r0;
   logic [127:0] r1;
   logic [127:0] busR;
   logic [1:0]   reg_dest;
   logic         wr_control;
   logic         enable_amba;
   logic [127:0] core_key;
   logic [127:0] core_block;
   logic         core_mode;
   logic         core_start;
   logic         core_abort;
   logic         core_done;
   logic [127:0] core_result;
   logic         busy;

   modport master (
      input  reg_conf, key, r0, r1, core_done, core_result,
      output busR, reg_dest, wr_control, enable_amba,
             core_key, core_block, core_mode, core_start, core_abort, busy
   );

   modport slave (
      output reg_conf, key, r0, r1, core_done, core_result,
      input  busR, reg_dest, wr_control, enable_amba,
             core_key, core_block, core_mode, core_start, core_abort, busy
   );
endinterface

// File: rtl/aes_seq_ctrl.sv
// Sequences one AES-128 block operation: snapshot, core handshake, optional
// CBC chaining, and write-back of result, IV and status to the register file.
module aes_seq_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 8
) (
   input  logic          ACLK,
   input  logic          ARSTn,
   aes_seq_ctrl_if.master bus
);

   localparam logic [7:0] LP_TMO = 8'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT, S_WB_RES, S_WB_IV, S_WB_ST
   } state_t;

   state_t        r_state, w_next;
   logic          r_start_d, r_start_edge;
   logic [127:0]  r_key, r_block, r_r0, r_iv, r_result;
   logic          r_mode, r_cbc;
   logic [7:0]    r_timer;
   logic [CNT_W-1:0] r_cnt;
   logic          r_ok, r_tmo, r_abt, r_ovr;
   logic          w_tmo_hit, w_sw_abort;
   logic [7:0]    w_cnt_field;
   logic          w_unused_conf;

   assign w_tmo_hit     = (r_timer + 8'd1) == LP_TMO;
   assign w_sw_abort    = bus.reg_conf[3];
   assign w_unused_conf = ^bus.reg_conf[127:4];

   if (CNT_W >= 8) begin : g_cnt_wide
      assign w_cnt_field = r_cnt[7:0];
   end else begin : g_cnt_narrow
      assign w_cnt_field = {{(8-CNT_W){1'b0}}, r_cnt};
   end

   always_ff @(posedge ACLK or negedge ARSTn) begin
      if (!ARSTn) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (r_start_edge) w_next = S_LOAD;
         S_LOAD:   w_next = S_START;
         S_START:  w_next = S_WAIT;
         S_WAIT: begin
            if (bus.core_done)                w_next = S_WB_RES;
            else if (w_tmo_hit || w_sw_abort) w_next = S_WB_ST;
         end
         S_WB_RES: w_next = r_cbc ? S_WB_IV : S_WB_ST;
         S_WB_IV:  w_next = S_WB_ST;
         S_WB_ST:  w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busR        = '0;
      bus.reg_dest    = 2'b00;
      bus.wr_control  = 1'b0;
      bus.enable_amba = 1'b1;
      bus.core_start  = 1'b0;
      bus.core_abort  = 1'b0;
      bus.busy        = (r_state != S_IDLE);
      case (r_state)
         S_START: bus.core_start = 1'b1;
         S_WAIT:  bus.core_abort = !bus.core_done && (w_tmo_hit || w_sw_abort);
         S_WB_RES: begin
            bus.wr_control  = 1'b1;
            bus.enable_amba = 1'b0;
            bus.reg_dest    = 2'b00;
            bus.busR        = r_result;
         end
         S_WB_IV: begin
            bus.wr_control  = 1'b1;
            bus.enable_amba = 1'b0;
            bus.reg_dest    = 2'b01;
            bus.busR        = r_mode ? r_r0 : r_result;
         end
         S_WB_ST: begin
            bus.wr_control  = 1'b1;
            bus.enable_amba = 1'b0;
            bus.reg_dest    = 2'b11;
            bus.busR        = {96'd0, 16'd0, w_cnt_field, 4'd0, r_ovr, r_abt, r_tmo, r_ok};
         end
         default: ;
      endcase
   end

   assign bus.core_key   = r_key;
   assign bus.core_block = r_block;
   assign bus.core_mode  = r_mode;

   always_ff @(posedge ACLK or negedge ARSTn) begin
      if (!ARSTn) begin
         r_start_d    <= 1'b0;
         r_start_edge <= 1'b0;
         r_key        <= '0;
         r_block      <= '0;
         r_r0         <= '0;
         r_iv         <= '0;
         r_result     <= '0;
         r_mode       <= 1'b0;
         r_cbc        <= 1'b0;
         r_timer      <= '0;
         r_cnt        <= '0;
         r_ok         <= 1'b0;
         r_tmo        <= 1'b0;
         r_abt        <= 1'b0;
         r_ovr        <= 1'b0;
      end else begin
         r_start_d    <= bus.reg_conf[0];
         r_start_edge <= bus.reg_conf[0] & ~r_start_d;
         // A start edge arriving mid-operation is dropped but remembered.
         if (r_start_edge && r_state != S_IDLE) r_ovr <= 1'b1;
         case (r_state)
            S_LOAD: begin
               r_key   <= bus.key;
               r_r0    <= bus.r0;
               r_iv    <= bus.r1;
               r_mode  <= bus.reg_conf[1];
               r_cbc   <= bus.reg_conf[2];
               r_block <= (bus.reg_conf[2] && !bus.reg_conf[1]) ? (bus.r0 ^ bus.r1) : bus.r0;
            end
            S_START: r_timer <= '0;
            S_WAIT: begin
               r_timer <= r_timer + 8'd1;
               if (bus.core_done) begin
                  r_result <= (r_mode && r_cbc) ? (bus.core_result ^ r_iv) : bus.core_result;
                  r_ok     <= 1'b1;
                  r_cnt    <= r_cnt + 1'b1;
               end else if (w_tmo_hit || w_sw_abort) begin
                  r_tmo <= w_tmo_hit;
                  r_abt <= w_sw_abort;
               end
            end
            S_WB_ST: begin
               r_ok  <= 1'b0;
               r_tmo <= 1'b0;
               r_abt <= 1'b0;
               r_ovr <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Directed bench for aes_seq_ctrl with an XOR stand-in core chosen so that the
// FIPS-197 plaintext maps to the FIPS-197 ciphertext.
module tb_aes_seq_ctrl;

   localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeefe;
   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55b;
   localparam logic [127:0] STUB_K = 128'h69d5c2eb2e2e624750541d3bbc692ba5;

   logic ACLK = 1'b0;
   logic ARSTn = 1'b1;
   always #5 ACLK = ~ACLK;

   aes_seq_ctrl_if bus();

   aes_seq_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(8)) dut (
      .ACLK (ACLK),
      .ARSTn(ARSTn),
      .bus  (bus)
   );

   typedef struct {
      logic [1:0]   dest;
      logic [127:0] data;
      int           cyc;
   } wr_t;

   typedef struct {
      logic         mode;
      logic         cbc;
      logic [127:0] key;
      logic [127:0] r0;
      logic [127:0] r1;
      int           lat;
      logic [127:0] e_block;
      logic [127:0] e_r2;
      logic [127:0] e_r1;
      logic [127:0] e_st;
      int           e_nwr;
   } vec_t;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   // stimulus-side state (written only by the main process)
   int stub_lat = 0;
   int spur_req = 0;
   int req_cyc, wq_base, st_base, ab_base, am_base;

   // monitor-side state (written only by the monitor)
   wr_t          wq[$];
   int           n_start = 0, n_abort = 0, amba_bad = 0;
   int           start_cyc = 0, abort_cyc = 0;
   logic [127:0] seen_block = '0, seen_key = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Stand-in core: answers lat cycles after core_start with block ^ STUB_K.
   initial begin : core_stub
      int pend;
      int spur_ack;
      logic [127:0] blk;
      pend = 0;
      spur_ack = 0;
      blk = '0;
      bus.core_done = 1'b0;
      bus.core_result = '0;
      forever begin
         @(negedge ACLK);
         #1;
         bus.core_done = 1'b0;
         if (spur_req != spur_ack) begin
            bus.core_done = 1'b1;
            bus.core_result = '1;
            spur_ack = spur_req;
         end
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               bus.core_done = 1'b1;
               bus.core_result = blk ^ STUB_K;
            end
         end
         if (bus.core_start && stub_lat != 0) begin
            pend = stub_lat;
            blk = bus.core_block;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge ACLK);
         #2;
         if (bus.wr_control) begin
            wq.push_back('{dest: bus.reg_dest, data: bus.busR, cyc: cyc});
            if (bus.enable_amba) amba_bad++;
         end
         if (bus.core_start) begin
            n_start++;
            start_cyc = cyc;
            seen_block = bus.core_block;
            seen_key = bus.core_key;
         end
         if (bus.core_abort) begin
            n_abort++;
            abort_cyc = cyc;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busR"},        bus.busR, '0);
      chk({tag, "_reg_dest"},    128'(bus.reg_dest), '0);
      chk({tag, "_wr_control"},  128'(bus.wr_control), '0);
      chk({tag, "_enable_amba"}, 128'(bus.enable_amba), 128'd1);
      chk({tag, "_core_key"},    bus.core_key, '0);
      chk({tag, "_core_block"},  bus.core_block, '0);
      chk({tag, "_core_mode"},   128'(bus.core_mode), '0);
      chk({tag, "_core_start"},  128'(bus.core_start), '0);
      chk({tag, "_core_abort"},  128'(bus.core_abort), '0);
      chk({tag, "_busy"},        128'(bus.busy), '0);
   endtask

   task automatic start_op(input logic mode, input logic cbc, input logic [127:0] k,
                           input logic [127:0] b0, input logic [127:0] b1, input int lat);
      stub_lat = lat;
      @(negedge ACLK);
      bus.key = k;
      bus.r0 = b0;
      bus.r1 = b1;
      bus.reg_conf = {124'd0, 1'b0, cbc, mode, 1'b1};
      req_cyc = cyc;
      wq_base = wq.size();
      st_base = n_start;
      ab_base = n_abort;
      am_base = amba_bad;
      @(negedge ACLK);
      bus.reg_conf[0] = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge ACLK);
         if (i > 2 && !bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk({tag, "_idle"}, 128'(ok), 128'd1);
   endtask

   task automatic run_op(input logic mode, input logic cbc, input logic [127:0] k,
                         input logic [127:0] b0, input logic [127:0] b1, input int lat,
                         input string tag);
      start_op(mode, cbc, k, b0, b1, lat);
      wait_idle(tag);
   endtask

   function automatic logic [127:0] last_status();
      if (wq.size() == 0) return '1;
      return wq[wq.size()-1].data;
   endfunction

   vec_t vecs[4];

   initial begin : main
      int nw;
      int ab0;
      int s0;
      vecs[0] = '{1'b0, 1'b0, KEY, PT,  128'd0, 11, PT,  CT,  128'd0, 128'h101, 2};
      vecs[1] = '{1'b0, 1'b1, KEY, PT,  128'd1, 11, PT1, CT1, CT1,    128'h201, 3};
      vecs[2] = '{1'b1, 1'b1, KEY, CT1, 128'd1, 11, CT1, PT,  CT1,    128'h301, 3};
      vecs[3] = '{1'b1, 1'b0, KEY, CT,  128'd0, 5,  CT,  PT,  128'd0, 128'h401, 2};

      bus.reg_conf = '0;
      bus.key = '0;
      bus.r0 = '0;
      bus.r1 = '0;
      #2 ARSTn = 1'b0;
      repeat (3) @(negedge ACLK);
      check_reset_outputs("rst");
      ARSTn = 1'b1;
      repeat (2) @(negedge ACLK);

      for (int i = 0; i < 4; i++) begin
         run_op(vecs[i].mode, vecs[i].cbc, vecs[i].key, vecs[i].r0, vecs[i].r1, vecs[i].lat,
                $sformatf("v%0d", i));
         nw = wq.size() - wq_base;
         chk($sformatf("v%0d_block", i), seen_block, vecs[i].e_block);
         chk($sformatf("v%0d_key", i), seen_key, vecs[i].key);
         chk($sformatf("v%0d_starts", i), 128'(n_start - st_base), 128'd1);
         chk($sformatf("v%0d_nwr", i), 128'(nw), 128'(vecs[i].e_nwr));
         chk($sformatf("v%0d_amba", i), 128'(amba_bad - am_base), 128'd0);
         if (nw == vecs[i].e_nwr) begin
            chk($sformatf("v%0d_dest0", i), 128'(wq[wq_base].dest), 128'd0);
            chk($sformatf("v%0d_r2", i), wq[wq_base].data, vecs[i].e_r2);
            chk($sformatf("v%0d_latency", i), 128'(wq[wq_base].cyc - req_cyc), 128'(4 + vecs[i].lat));
            if (vecs[i].cbc) begin
               chk($sformatf("v%0d_dest1", i), 128'(wq[wq_base+1].dest), 128'd1);
               chk($sformatf("v%0d_r1", i), wq[wq_base+1].data, vecs[i].e_r1);
            end
            chk($sformatf("v%0d_dest_st", i), 128'(wq[wq_base+nw-1].dest), 128'd3);
            chk($sformatf("v%0d_status", i), wq[wq_base+nw-1].data, vecs[i].e_st);
         end
         chk($sformatf("v%0d_busy_after", i), 128'(bus.busy), 128'd0);
      end

      // Fresh reset so the error-path statuses start from a zero count.
      @(negedge ACLK);
      ARSTn = 1'b0;
      @(negedge ACLK);
      ARSTn = 1'b1;

      run_op(1'b0, 1'b0, KEY, PT, 128'd0, 0, "tmo");
      chk("tmo_abort_cnt", 128'(n_abort - ab_base), 128'd1);
      chk("tmo_abort_delay", 128'(abort_cyc - start_cyc), 128'd64);
      chk("tmo_nwr", 128'(wq.size() - wq_base), 128'd1);
      chk("tmo_status", last_status(), 128'h002);

      start_op(1'b0, 1'b0, KEY, PT, 128'd0, 0);
      repeat (5) @(negedge ACLK);
      bus.reg_conf[3] = 1'b1;
      s0 = cyc;
      @(negedge ACLK);
      bus.reg_conf[3] = 1'b0;
      wait_idle("abt");
      chk("abt_abort_cnt", 128'(n_abort - ab_base), 128'd1);
      chk("abt_abort_cycle", 128'(abort_cyc), 128'(s0));
      chk("abt_status", last_status(), 128'h004);

      start_op(1'b0, 1'b0, KEY, PT, 128'd0, 11);
      repeat (3) @(negedge ACLK);
      bus.reg_conf[0] = 1'b1;
      @(negedge ACLK);
      bus.reg_conf[0] = 1'b0;
      wait_idle("ovr");
      repeat (10) @(negedge ACLK);
      chk("ovr_starts", 128'(n_start - st_base), 128'd1);
      chk("ovr_busy_after", 128'(bus.busy), 128'd0);
      chk("ovr_nwr", 128'(wq.size() - wq_base), 128'd2);
      chk("ovr_status", last_status(), 128'h109);

      nw = wq.size();
      spur_req = spur_req + 1;
      repeat (4) @(negedge ACLK);
      chk("spur_busy", 128'(bus.busy), 128'd0);
      chk("spur_nwr", 128'(wq.size() - nw), 128'd0);

      start_op(1'b0, 1'b0, KEY, PT, 128'd0, 0);
      repeat (4) @(negedge ACLK);
      chk("mid_busy_before", 128'(bus.busy), 128'd1);
      ab0 = n_abort;
      ARSTn = 1'b0;
      #1;
      check_reset_outputs("mid");
      @(negedge ACLK);
      ARSTn = 1'b1;
      repeat (2) @(negedge ACLK);
      chk("mid_no_abort", 128'(n_abort - ab0), 128'd0);

      for (int i = 0; i < 256; i++) begin
         run_op(1'b0, 1'b0, KEY, PT, 128'd0, 1, "wrap");
         if (i == 254) chk("wrap_255", last_status(), 128'hFF01);
         if (i == 255) chk("wrap_256", last_status(), 128'h0001);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
